aes_key_expand: RTL and testbench

Iterative AES-128 key schedule generator sitting directly upstream of the `aes` encryption core. It loads a 128-bit cipher key on `start` and streams the 11 round keys (round 0 through round 10) one at a time over a valid/ready handshake, computing each next key on the fly from the current one. No key storage beyond the current round key is required.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_sbox.sv | 33 +++
 rtl/aes_key_expand.sv | 128 ++++++++++++
 tb/tb_aes_key_expand.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the AES-128 key schedule and the AES core.
//   NR          : number of cipher rounds (10 for AES-128), also the last round index
//   aes_word_t  : 32-bit key-schedule word
//   RCON        : round constants, indexed 1..10
//   kex_state_t : key-expansion FSM states
//   rcon_for()  : range-safe round-constant lookup (0 outside 1..10)
package aes_pkg;

    localparam int NR = 10;

    typedef logic [31:0] aes_word_t;

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } kex_state_t;

    // Indices outside 1..10 only occur after the last round, where the result is unused.
    function automatic logic [7:0] rcon_for(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            rc = RCON[idx];
        end
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox
// Combinational AES forward S-box lookup (one byte).
// Ports:
//   value       in  8  byte to substitute
//   substituted out 8  S-box image of value
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] substituted
);

    // Element [0] is the leftmost byte, so row 0 starts with S(00)=63.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign substituted = SBOX_TABLE[value];

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand
// Iterative AES-128 key schedule. Loads a cipher key on start and streams
// round keys 0..10 over a valid/ready handshake, computing each next key
// from the current one (only the current round key is stored).
// Ports:
//   clk        in  1    rising-edge clock
//   reset      in  1    asynchronous, active-low reset
//   key_in     in  128  cipher key, key_in[127:96] is word w0
//   start      in  1    begin a new expansion
//   rk_ready   in  1    downstream ready for round_key
//   round_key  out 128  current round key
//   round_idx  out 4    index of round_key (0..10)
//   rk_valid   out 1    round_key/round_idx valid
//   busy       out 1    expansion in progress
//   done       out 1    one-cycle pulse after round 10 is transferred
// Build option:
//   AES_KEYEXP_ABORT_EN  when defined, start during an expansion aborts it
//                        and restarts from the new key; otherwise start is
//                        ignored until the expansion completes.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         start,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    kex_state_t   state;
    kex_state_t   next_state;
    logic [127:0] next_key;
    logic [3:0]   next_idx;
    logic         next_done;

    aes_word_t w0, w1, w2, w3;
    aes_word_t rot_word;
    aes_word_t sub_word;
    aes_word_t t_word;
    aes_word_t n0, n1, n2, n3;
    logic [3:0] new_idx;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    assign rot_word = {w3[23:0], w3[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sub
            aes_sbox u_sbox (
                .value       (rot_word[8*g +: 8]),
                .substituted (sub_word[8*g +: 8])
            );
        end
    endgenerate

    // The round constant belongs to the key being produced, hence idx + 1.
    assign new_idx = round_idx + 4'd1;
    assign t_word  = sub_word ^ {rcon_for(new_idx), 24'h000000};
    assign n0      = w0 ^ t_word;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;

    // Valid and busy both mean "in EMIT"; they come straight from the state flop.
    assign rk_valid = (state == EMIT);
    assign busy     = (state == EMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            round_key <= next_key;
            round_idx <= next_idx;
            done      <= next_done;
        end
    end

    // Without a transfer everything holds, which gives the stall behaviour.
    always_comb begin
        next_state = state;
        next_key   = round_key;
        next_idx   = round_idx;
        next_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = EMIT;
                    next_key   = key_in;
                    next_idx   = 4'd0;
                end
            end
            EMIT: begin
`ifdef AES_KEYEXP_ABORT_EN
                if (start) begin
                    next_key = key_in;
                    next_idx = 4'd0;
                end else
`endif
                if (rk_ready) begin
                    if (round_idx == LAST_IDX) begin
                        next_state = IDLE;
                        next_done  = 1'b1;
                    end else begin
                        next_key = {n0, n1, n2, n3};
                        next_idx = new_idx;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand
// Self-checking bench for aes_key_expand. Expected round keys come from a
// FIPS-197 style word-array key schedule whose S-box is derived from
// GF(2^8) inversion plus the affine map. Known-answer vectors, stall,
// reset, restart-while-busy and back-to-back sequences, and random keys
// with random backpressure.
// Build option: AES_KEYEXP_ABORT_EN selects the abort expectations.
module tb_aes_key_expand;

    localparam int LAST = 10;

    logic         clk;
    logic         reset;
    logic [127:0] key_in;
    logic         start;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         busy;
    logic         done;

    int total;
    int bad;

    logic [7:0]   sbox_m   [0:255];
    logic [127:0] exp_keys [0:10];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } kat_t;

    kat_t kat_tab [0:4];

    aes_key_expand dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .start     (start),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) helpers for the reference S-box.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Classic 44-word key schedule.
    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]],
                        sbox_m[temp[15:8]], sbox_m[temp[7:0]]};
                temp = temp ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= LAST; r++) begin
            exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [127:0] k, input logic r);
        start    = s;
        key_in   = k;
        rk_ready = r;
        tick();
    endtask

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called from a cycle where the DUT is IDLE; returns in the round-0 cycle.
    task automatic begin_exp(input logic [127:0] key);
        build_model(key);
        applyStimulus(1'b1, key, 1'b1);
        start  = 1'b0;
        key_in = junk();
    endtask

    // Consumes rounds first_idx..10, checking every presented cycle, then
    // checks the done cycle and returns in it.
    task automatic stream(input int first_idx, input int stall_round,
                          input int stall_len, input int rand_pct);
        int idx;
        int scnt;
        int cycles;
        logic rdy;
        idx    = first_idx;
        scnt   = 0;
        cycles = 0;
        while (idx <= LAST && cycles < 300) begin
            checkOutput("rk_valid", rk_valid, 1);
            checkOutput("busy", busy, 1);
            checkOutput("done_early", done, 0);
            checkOutput("round_idx", round_idx, idx);
            checkOutput("round_key", round_key, exp_keys[idx]);
            if (idx == stall_round && scnt < stall_len) begin
                rdy = 1'b0;
                scnt++;
            end else if (int'($urandom_range(99)) < rand_pct) begin
                rdy = 1'b0;
            end else begin
                rdy = 1'b1;
            end
            applyStimulus(1'b0, key_in, rdy);
            cycles++;
            if (rdy) idx++;
        end
        if (idx <= LAST) begin
            total++;
            bad++;
            $display("[TB] FAIL stream_timeout actual=idx%0d required=idx%0d", idx, LAST + 1);
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_after", busy, 0);
        checkOutput("valid_after", rk_valid, 0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;

        kat_tab[0] = '{key: K1, idx: 0,  rk: K1};
        kat_tab[1] = '{key: K1, idx: 1,  rk: 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        kat_tab[2] = '{key: K1, idx: 10, rk: 128'h13111d7fe3944a17f307a78b4d2b30c5};
        kat_tab[3] = '{key: K2, idx: 1,  rk: 128'ha0fafe1788542cb123a339392a6c7605};
        kat_tab[4] = '{key: K2, idx: 10, rk: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        build_sbox();

        #3;
        checkOutput("reset_round_key", round_key, 0);
        checkOutput("reset_round_idx", round_idx, 0);
        checkOutput("reset_rk_valid", rk_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        checkOutput("idle_valid", rk_valid, 0);

        $display("[TB] known-answer vectors");
        for (int v = 0; v < 5; v++) begin
            begin_exp(kat_tab[v].key);
            checkOutput("model_kat", exp_keys[kat_tab[v].idx], kat_tab[v].rk);
            rk_ready = 1'b1;
            for (int c = 0; c < kat_tab[v].idx; c++) tick();
            checkOutput("kat_idx", round_idx, kat_tab[v].idx);
            checkOutput("kat_key", round_key, kat_tab[v].rk);
            for (int c = kat_tab[v].idx; c < 11; c++) tick();
            checkOutput("kat_done_n12", done, 1);
            tick();
            checkOutput("kat_done_pulse_end", done, 0);
        end

        $display("[TB] backpressure at round 4");
        begin_exp(K1);
        stream(0, 4, 3, 0);
        tick();

        $display("[TB] reset at round 6");
        begin_exp(K2);
        rk_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        checkOutput("pre_reset_idx", round_idx, 6);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_round_key", round_key, 0);
        checkOutput("async_round_idx", round_idx, 0);
        checkOutput("async_rk_valid", rk_valid, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_done", done, 0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("post_reset_valid", rk_valid, 0);
            checkOutput("post_reset_busy", busy, 0);
        end
        begin_exp(K1);
        stream(0, -1, 0, 0);
        tick();

        $display("[TB] start at round 3");
        begin_exp(K1);
        rk_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        checkOutput("pre_start_idx", round_idx, 3);
`ifdef AES_KEYEXP_ABORT_EN
        build_model(K2);
        applyStimulus(1'b1, K2, 1'b1);
        start = 1'b0;
        stream(0, -1, 0, 0);
`else
        applyStimulus(1'b1, K2, 1'b1);
        start = 1'b0;
        stream(4, -1, 0, 0);
        tick();
        checkOutput("ignored_start_idle", rk_valid, 0);
`endif
        tick();

        $display("[TB] back-to-back");
        begin_exp(K2);
        stream(0, -1, 0, 20);
        begin_exp(K1);
        stream(0, -1, 0, 0);
        tick();

        $display("[TB] random keys with random backpressure");
        for (int n = 0; n < 6; n++) begin
            for (int g = 0; g < int'($urandom_range(2)); g++) applyStimulus(1'b0, junk(), 1'b0);
            begin_exp(junk());
            stream(0, -1, 0, 30);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
